// File: rtl/pipe_pkg.sv
// Constants shared by the 10-bit 4-operand arithmetic pipeline and its result sink.
package pipe_pkg;
    localparam int F_W        = 10;
    localparam int SINK_DEPTH = 4;
    localparam int SINK_SUM_W = 16;
endpackage : pipe_pkg

// File: rtl/pipe_sink_mem.sv
// DEPTH x W register array for the result sink: one write port, asynchronous read.
module pipe_sink_mem #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] entries [DEPTH];

    // Storage holds no reset; the owner tracks which entries are live.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    entry_reg <= wdata;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rdata = entries[raddr];
endmodule : pipe_sink_mem

// File: rtl/pipe_result_sink.sv
// Non-stalling FWFT sink for pipeline results with sticky overflow flag.
// Optional running sum/max statistics when PIPE_SINK_STATS_EN is defined.
module pipe_result_sink
    import pipe_pkg::*;
#(
    parameter int W     = F_W,
    parameter int DEPTH = SINK_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int SUM_W = SINK_SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_f,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [SUM_W-1:0] acc_sum,
    output logic [W-1:0]     acc_max
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg;
    logic             push, pop, drop;
    logic [W-1:0]     head_data;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign out_f     = out_valid ? head_data : '0;

    pipe_sink_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (in_f),
        .raddr (rd_ptr_reg),
        .rdata (head_data)
    );

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)         overflow_reg <= 1'b1;
            else if (clr_ovf) overflow_reg <= 1'b0;
        end
    end

`ifdef PIPE_SINK_STATS_EN
    logic [SUM_W-1:0] acc_sum_reg;
    logic [W-1:0]     acc_max_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_reg <= '0;
            acc_max_reg <= '0;
        end else if (push) begin
            acc_sum_reg <= acc_sum_reg + SUM_W'(in_f);
            if (in_f > acc_max_reg) acc_max_reg <= in_f;
        end
    end

    assign acc_sum = acc_sum_reg;
    assign acc_max = acc_max_reg;
`else
    assign acc_sum = '0;
    assign acc_max = '0;
`endif
endmodule : pipe_result_sink

// File: tb/tb_pipe_result_sink.sv
// Directed bench for pipe_result_sink with a queue scoreboard checked every cycle.
module tb_pipe_result_sink;
    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int SUM_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [W-1:0]     in_f;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_f;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clr_ovf;
    logic [SUM_W-1:0] acc_sum;
    logic [W-1:0]     acc_max;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [W-1:0]     sb[$];
    logic             exp_ovf = 1'b0;
    logic [SUM_W-1:0] exp_sum = '0;
    logic [W-1:0]     exp_max = '0;

    always #5 clk = ~clk;

    pipe_result_sink #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_f      (in_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .acc_sum   (acc_sum),
        .acc_max   (acc_max)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [W-1:0] head;
        head = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, ".count"}, 32'(count), 32'(sb.size()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(sb.size() == DEPTH));
        chk({tag, ".out_f"}, 32'(out_f), 32'(head));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef PIPE_SINK_STATS_EN
        chk({tag, ".acc_sum"}, 32'(acc_sum), 32'(exp_sum));
        chk({tag, ".acc_max"}, 32'(acc_max), 32'(exp_max));
`else
        chk({tag, ".acc_sum"}, 32'(acc_sum), 32'(0));
        chk({tag, ".acc_max"}, 32'(acc_max), 32'(0));
`endif
        $display("%0t %s cnt=%0d vld=%0b f=%0d ovf=%0b", $time, tag, count, out_valid, out_f, overflow);
    endtask

    // Advance one clock: update the reference queue from the inputs in force, then check.
    task automatic cycle(input string tag);
        bit popped;
        popped = (sb.size() != 0) && out_ready;
        if (popped) void'(sb.pop_front());
        if (in_valid && ((sb.size() < DEPTH) || popped)) begin
            sb.push_back(in_f);
            exp_sum = exp_sum + SUM_W'(in_f);
            if (in_f > exp_max) exp_max = in_f;
        end else if (in_valid) begin
            exp_ovf = 1'b1;
        end else if (clr_ovf) begin
            exp_ovf = 1'b0;
        end
        if (in_valid && !((sb.size() <= DEPTH) && !exp_ovf) && clr_ovf && sb.size() < DEPTH) exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic push1(input string tag, input logic [W-1:0] v);
        in_valid = 1'b1;
        in_f     = v;
        cycle(tag);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle(tag);
        out_ready = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        exp_ovf = 1'b0;
        exp_sum = '0;
        exp_max = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_f      = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        #1;
        check_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single push shows up one edge later
        push1("t1_push", 10'd18);
        chk("t1_out_f", 32'(out_f), 32'd18);
        drain("t1_drain");

        // 2: fill, drop one, then drain in order
        push1("t2_push", 10'd18);
        push1("t2_push", 10'd13);
        push1("t2_push", 10'd26);
        push1("t2_push", 10'd7);
        chk("t2_full", 32'(full), 32'd1);
        push1("t2_drop", 10'd9);
        chk("t2_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        chk("t2_head0", 32'(out_f), 32'd18);
        cycle("t2_pop");
        chk("t2_head1", 32'(out_f), 32'd13);
        cycle("t2_pop");
        chk("t2_head2", 32'(out_f), 32'd26);
        cycle("t2_pop");
        chk("t2_head3", 32'(out_f), 32'd7);
        cycle("t2_pop");
        out_ready = 1'b0;
        chk("t2_empty", 32'(empty), 32'd1);
        cycle("t2_empty_ready_idle");

        // 3: push and pop together while full
        for (int i = 1; i <= DEPTH; i++) push1("t3_fill", W'(i));
        in_valid  = 1'b1;
        in_f      = 10'd5;
        out_ready = 1'b1;
        cycle("t3_both");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_ovf_kept", 32'(overflow), 32'd1);
        cycle("t3_hold");
        drain("t3_drain");

        // 4: continuous stream wraps the pointers
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_f = W'(100 + 37 * i);
            cycle("t4_stream");
        end
        in_valid = 1'b0;
        drain("t4_drain");

        // 5: clear alone, drop, clear racing a drop, clear alone
        clr_ovf = 1'b1;
        cycle("t5_clr");
        clr_ovf = 1'b0;
        chk("t5_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) push1("t5_fill", W'(200 + i));
        push1("t5_drop", 10'd1);
        clr_ovf = 1'b1;
        push1("t5_drop_clr", 10'd2);
        clr_ovf = 1'b0;
        chk("t5_set_wins", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        cycle("t5_clr_only");
        clr_ovf = 1'b0;
        chk("t5_clr_final", 32'(overflow), 32'd0);
        drain("t5_drain");

        // 6: mid-stream reset, then stats from a clean start
        for (int i = 0; i < 3; i++) push1("t6_fill", W'(50 + i));
        chk("t6_count3", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        clear_model();
        check_state("t6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push1("t6_stat", 10'd18);
        push1("t6_stat", 10'd13);
        push1("t6_stat", 10'd26);
`ifdef PIPE_SINK_STATS_EN
        chk("t6_acc_sum", 32'(acc_sum), 32'd57);
        chk("t6_acc_max", 32'(acc_max), 32'd26);
`else
        chk("t6_acc_sum_tied", 32'(acc_sum), 32'd0);
        chk("t6_acc_max_tied", 32'(acc_max), 32'd0);
`endif
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_pipe_result_sink
